// File: rtl/multiwave_generator.sv
// Phase-accumulator audio oscillator: saw, triangle, square and pulse outputs
// as two's-complement samples. Setting changes are deferred to phase wrap or sync.
module multiwave_generator #(
  parameter int BITSIZE   = 24,
  parameter int PHASESIZE = 16
) (
  input  logic                        lrclk,
  input  logic                        resetn,
  input  logic                        enable,
  input  logic        [PHASESIZE-1:0] freq,
  input  logic        [1:0]           mode,
  input  logic        [PHASESIZE-1:0] duty,
  input  logic                        sync,
  output logic signed [BITSIZE-1:0]   out,
  output logic                        wrap
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state, state_nxt;
  logic [PHASESIZE-1:0] phase;
  logic [PHASESIZE-1:0] freq_act;
  logic [1:0]           mode_act;
  logic [PHASESIZE-1:0] duty_act;

  logic                 active_p0;
  logic [PHASESIZE:0]   sum_p0;
  logic [PHASESIZE-1:0] u_p0;
  logic                 reload_p0;

  function automatic logic [PHASESIZE-1:0] wave_u(
    input logic [PHASESIZE-1:0] ph,
    input logic [1:0]           m,
    input logic [PHASESIZE-1:0] d
  );
    logic [PHASESIZE-1:0] u;
    case (m)
      2'd0:    u = ph;
      2'd1:    u = {ph[PHASESIZE-2:0] ^ {(PHASESIZE-1){ph[PHASESIZE-1]}}, 1'b0};
      2'd2:    u = {PHASESIZE{~ph[PHASESIZE-1]}};
      default: u = (ph < d) ? '1 : '0;
    endcase
    return u;
  endfunction

  // MSB-aligned width fit: extra output LSBs are zero, surplus phase LSBs are dropped.
  function automatic logic [BITSIZE-1:0] fit_width(input logic [PHASESIZE-1:0] u);
    logic [BITSIZE-1:0] v;
    v = '0;
    for (int i = 0; i < BITSIZE; i++) begin
      if (i + PHASESIZE - BITSIZE >= 0) v[i] = u[i + PHASESIZE - BITSIZE];
    end
    return v;
  endfunction

  function automatic logic signed [BITSIZE-1:0] to_twos(input logic [BITSIZE-1:0] v);
    return signed'({~v[BITSIZE-1], v[BITSIZE-2:0]});
  endfunction

  always_ff @(posedge lrclk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable)  state_nxt = RUN;
      RUN:     if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: accumulate and shape the current phase with the active settings
  assign active_p0 = (state == RUN) && enable;
  assign sum_p0    = {1'b0, phase} + {1'b0, freq_act};
  assign u_p0      = wave_u(phase, mode_act, duty_act);
  assign reload_p0 = !active_p0 || sync || sum_p0[PHASESIZE];

  // Stage p1: registered sample, next phase and wrap strobe
  always_ff @(posedge lrclk) begin
    if (!resetn) begin
      phase    <= '0;
      freq_act <= '0;
      mode_act <= '0;
      duty_act <= '0;
      out      <= '0;
      wrap     <= 1'b0;
    end else begin
      if (reload_p0) begin
        freq_act <= freq;
        mode_act <= mode;
        duty_act <= duty;
      end
      if (!active_p0) begin
        phase <= '0;
        wrap  <= 1'b0;
        out   <= '0;
      end else begin
        out <= to_twos(fit_width(u_p0));
        if (sync) begin
          phase <= '0;
          wrap  <= 1'b0;
        end else begin
          phase <= sum_p0[PHASESIZE-1:0];
          wrap  <= sum_p0[PHASESIZE];
        end
      end
    end
  end

endmodule

// File: tb/tb_multiwave_generator.sv
// Directed bench for multiwave_generator at three output widths sharing one
// stimulus, checked every cycle against a phase-level model plus literal values.
module tb_multiwave_generator;

  logic        lrclk = 1'b0;
  logic        resetn, enable, sync;
  logic [15:0] freq, duty;
  logic [1:0]  mode;
  logic [23:0] o24;
  logic [15:0] o16;
  logic [7:0]  o8;
  logic        w24, w16, w8;

  int vectors = 0;
  int miscompares = 0;

  always #5 lrclk = ~lrclk;

  multiwave_generator #(.BITSIZE(24), .PHASESIZE(16)) dut24 (
    .lrclk(lrclk), .resetn(resetn), .enable(enable), .freq(freq), .mode(mode),
    .duty(duty), .sync(sync), .out(o24), .wrap(w24));
  multiwave_generator #(.BITSIZE(16), .PHASESIZE(16)) dut16 (
    .lrclk(lrclk), .resetn(resetn), .enable(enable), .freq(freq), .mode(mode),
    .duty(duty), .sync(sync), .out(o16), .wrap(w16));
  multiwave_generator #(.BITSIZE(8), .PHASESIZE(16)) dut8 (
    .lrclk(lrclk), .resetn(resetn), .enable(enable), .freq(freq), .mode(mode),
    .duty(duty), .sync(sync), .out(o8), .wrap(w8));

  // Model: phase as an integer in [0, 65536), unsigned wave held as an integer.
  int m_ph = 0, m_f = 0, m_m = 0, m_d = 0, m_u = 0;
  bit m_run = 0, m_zero = 1, m_wrap = 0;

  function automatic int model_wave(int ph, int m, int d);
    case (m)
      0:       return ph;
      1:       return (ph < 32768) ? 2 * ph : 2 * (65535 - ph);
      2:       return (ph < 32768) ? 65535 : 0;
      default: return (ph < d) ? 65535 : 0;
    endcase
  endfunction

  always @(posedge lrclk) begin
    int s;
    if (!resetn) begin
      m_ph = 0; m_f = 0; m_m = 0; m_d = 0; m_run = 0; m_zero = 1; m_wrap = 0;
    end else if (!m_run || !enable) begin
      m_run = enable; m_ph = 0; m_wrap = 0; m_zero = 1;
      m_f = int'(freq); m_m = int'(mode); m_d = int'(duty);
    end else begin
      s = m_ph + m_f;
      m_u = model_wave(m_ph, m_m, m_d);
      m_zero = 0;
      if (sync) begin
        m_ph = 0; m_wrap = 0;
      end else begin
        m_ph = s % 65536; m_wrap = (s >= 65536);
      end
      if (sync || s >= 65536) begin
        m_f = int'(freq); m_m = int'(mode); m_d = int'(duty);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_wrap();
    int n = 0;
    do begin
      @(negedge lrclk);
      n++;
    end while (!w24 && n < 64);
    if (!w24) chk("wrap_timeout", 0, 1);
  endtask

  task automatic wait_out(input int target);
    int n = 0;
    do begin
      @(negedge lrclk);
      n++;
    end while (int'(o24) != target && n < 64);
    if (int'(o24) != target) chk("out_timeout", int'(o24), target);
  endtask

  initial begin
    int cnt, cnt2, mx, n;
    resetn = 1'b0; enable = 1'b1; freq = 16'h1000; mode = 2'd0; duty = 16'h0; sync = 1'b0;

    fork
      forever begin
        @(negedge lrclk);
        chk("out24", int'(o24), m_zero ? 0 : ((m_u * 256) ^ 'h800000));
        chk("out16", int'(o16), m_zero ? 0 : (m_u ^ 'h8000));
        chk("out8",  int'(o8),  m_zero ? 0 : ((m_u / 256) ^ 'h80));
        chk("wrap",  int'({w24, w16, w8}), m_wrap ? 7 : 0);
      end
    join_none

    repeat (3) begin
      @(negedge lrclk);
      chk("reset_out", int'(o24), 0);
      chk("reset_wrap", int'(w24), 0);
    end
    resetn = 1'b1;
    @(negedge lrclk);
    chk("idle_exit_out", int'(o24), 0);
    @(negedge lrclk);
    chk("first_run", int'(o24), 'h800000);
    @(negedge lrclk);
    chk("saw_step", int'(o24), 'h900000);

    cnt = 0;
    repeat (48) begin
      @(negedge lrclk);
      if (w24) cnt++;
    end
    chk("saw_wrap_count", cnt, 3);

    wait_out('h400000);
    chk("fit_b8", int'(o8), 'h40);
    chk("fit_b16", int'(o16), 'h4000);

    mode = 2'd1;
    wait_wrap();
    mx = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge lrclk);
      if (i == 0) chk("tri_first", int'(o24), 'h800000);
      if (i == 1) chk("tri_second", int'(o24), 'hA00000);
      if (int'(o24 ^ 24'h800000) > mx) mx = int'(o24 ^ 24'h800000);
    end
    chk("tri_peak", mx ^ 'h800000, 'h7FFE00);

    mode = 2'd3; duty = 16'h4000;
    wait_wrap();
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge lrclk);
      if (o24 == 24'h7FFF00) cnt++;
      if (o24 == 24'h800000) cnt2++;
    end
    chk("pulse_high", cnt, 4);
    chk("pulse_low", cnt2, 12);

    duty = 16'h0;
    wait_wrap();
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge lrclk);
      if (o24 == 24'h800000) cnt++;
    end
    chk("pulse_duty0", cnt, 16);

    mode = 2'd0;
    wait_wrap();
    wait_out('h500000);
    freq = 16'h2000;
    wait_wrap();
    n = 0;
    do begin
      @(negedge lrclk);
      n++;
    end while (!w24 && n < 64);
    chk("new_period", n, 8);

    repeat (3) @(negedge lrclk);
    freq = 16'h0800; sync = 1'b1;
    @(negedge lrclk);
    sync = 1'b0;
    chk("sync_wrap", int'(w24), 0);
    @(negedge lrclk);
    chk("sync_phase0", int'(o24), 'h800000);
    @(negedge lrclk);
    chk("sync_newfreq", int'(o24), 'h880000);

    freq = 16'h0; sync = 1'b1;
    @(negedge lrclk);
    sync = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(negedge lrclk);
      if (w24) cnt++;
    end
    chk("freq0_nowrap", cnt, 0);
    chk("freq0_out", int'(o24), 'h800000);

    freq = 16'h1000; sync = 1'b1;
    @(negedge lrclk);
    sync = 1'b0;
    repeat (5) @(negedge lrclk);
    enable = 1'b0;
    @(negedge lrclk);
    chk("disable_out", int'(o24), 0);
    enable = 1'b1;
    @(negedge lrclk);
    chk("reenable_out", int'(o24), 0);
    @(negedge lrclk);
    chk("restart_phase0", int'(o24), 'h800000);

    repeat (4) @(negedge lrclk);
    resetn = 1'b0;
    @(negedge lrclk);
    chk("midrun_reset", int'(o24), 0);
    resetn = 1'b1;
    repeat (6) @(negedge lrclk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
